// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: op codes and multiplier FSM states.
package alu_pkg;

  localparam logic [3:0] ALU_AND   = 4'h0;
  localparam logic [3:0] ALU_OR    = 4'h1;
  localparam logic [3:0] ALU_NOR   = 4'h2;
  localparam logic [3:0] ALU_XOR   = 4'h3;
  localparam logic [3:0] ALU_ADD   = 4'h4;
  localparam logic [3:0] ALU_SUB   = 4'h5;
  localparam logic [3:0] ALU_SLT   = 4'h6;
  localparam logic [3:0] ALU_SLTU  = 4'h7;
  localparam logic [3:0] ALU_SLL   = 4'h8;
  localparam logic [3:0] ALU_SRL   = 4'h9;
  localparam logic [3:0] ALU_SRA   = 4'hA;
  localparam logic [3:0] ALU_MULTU = 4'hB;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } mul_state_e;

endpackage

// File: rtl/alu_mult_seq.sv
// Iterative shift-add unsigned multiplier: one partial product per cycle, WIDTH cycles per op.
// The final product is presented combinationally in the same cycle done is high.
module alu_mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);
  import alu_pkg::*;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mul_state_e           state_q, state_d;
  logic [2*WIDTH-1:0]   mcand, acc, addend;
  logic [WIDTH-1:0]     mplier;
  logic [CW-1:0]        cnt;

  assign busy    = (state_q == MUL);
  assign done    = busy && (cnt == LAST);
  assign addend  = mplier[0] ? mcand : '0;
  assign product = acc + addend;

  // State register; reset abandons any multiply in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: start launches a multiply, the last iteration returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = MUL;
      MUL:     if (cnt == LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: load operands on start, then one shift-add step per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (state_q == IDLE && start) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
    end else if (busy) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute-stage ALU: single-cycle logic/arith/compare/shift ops, iterative MULTU,
// valid/ready on both sides and a single-entry output register.
module alu_exec_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [WIDTH-1:0] out_hi,
  output logic             out_zero,
  output logic             out_ovf,
  output logic             out_err
);
  import alu_pkg::*;

  localparam int SHW = $clog2(WIDTH);

  logic                 run_q;
  logic                 accept, start_mul;
  logic                 mul_busy, mul_done;
  logic [2*WIDTH-1:0]   mul_product;
  logic [WIDTH-1:0]     alu_res, sum, diff;
  logic                 alu_ovf, alu_err;
  logic [SHW-1:0]       shamt;

  assign in_ready  = run_q && !mul_busy && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign start_mul = accept && (in_op == ALU_MULTU);
  assign shamt     = in_a[SHW-1:0];
  assign sum       = in_a + in_b;
  assign diff      = in_a - in_b;

  alu_mult_seq #(.WIDTH(WIDTH)) u_mult (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start_mul),
    .a       (in_a),
    .b       (in_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // Hold off acceptance until the first clock after reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  // Single-cycle result, signed overflow and illegal-op detection.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_err = 1'b0;
    case (in_op)
      ALU_AND:   alu_res = in_a & in_b;
      ALU_OR:    alu_res = in_a | in_b;
      ALU_NOR:   alu_res = ~(in_a | in_b);
      ALU_XOR:   alu_res = in_a ^ in_b;
      ALU_ADD: begin
        alu_res = sum;
        alu_ovf = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (sum[WIDTH-1] != in_a[WIDTH-1]);
      end
      ALU_SUB: begin
        alu_res = diff;
        alu_ovf = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (diff[WIDTH-1] != in_a[WIDTH-1]);
      end
      ALU_SLT:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      ALU_SLTU:  alu_res = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
      ALU_SLL:   alu_res = in_b << shamt;
      ALU_SRL:   alu_res = in_b >> shamt;
      ALU_SRA:   alu_res = $signed(in_b) >>> shamt;
      ALU_MULTU: alu_res = '0;
      default:   alu_err = 1'b1;
    endcase
  end

  // Output register: multiplier completion, new single-cycle result, or consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_hi     <= '0;
      out_zero   <= 1'b0;
      out_ovf    <= 1'b0;
      out_err    <= 1'b0;
    end else if (mul_done) begin
      out_valid  <= 1'b1;
      out_result <= mul_product[WIDTH-1:0];
      out_hi     <= mul_product[2*WIDTH-1:WIDTH];
      out_zero   <= (mul_product == '0);
      out_ovf    <= 1'b0;
      out_err    <= 1'b0;
    end else if (accept) begin
      if (start_mul) begin
        out_valid  <= 1'b0;
      end else begin
        out_valid  <= 1'b1;
        out_result <= alu_res;
        out_hi     <= '0;
        out_zero   <= (alu_res == '0);
        out_ovf    <= alu_ovf;
        out_err    <= alu_err;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed vector table, hand-written
// multi-cycle sequences and randomized ops against an arithmetic reference model.
module tb_alu_exec_stage;
  import alu_pkg::*;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] hi;
    logic        zero;
    logic        ovf;
    logic        err;
  } res_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    res_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_op = '0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic [31:0] out_hi;
  logic        out_zero;
  logic        out_ovf;
  logic        out_err;

  int tests = 0;
  int fails = 0;

  alu_exec_stage #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_hi     (out_hi),
    .out_zero   (out_zero),
    .out_ovf    (out_ovf),
    .out_err    (out_err)
  );

  // 100 MHz free-running clock.
  always #5 clk = ~clk;

  // Reference model built from the op definitions using 64-bit arithmetic.
  function automatic res_t refModel(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    res_t r;
    longint sa, sb, s;
    longint unsigned ua, ub;
    logic [63:0] p;
    int t, sh;
    r  = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    sh = int'(a[4:0]);
    p  = '0;
    case (op)
      4'h0: r.res = a & b;
      4'h1: r.res = a | b;
      4'h2: r.res = ~(a | b);
      4'h3: r.res = a ^ b;
      4'h4, 4'h5: begin
        s = (op == 4'h4) ? sa + sb : sa - sb;
        r.res = s[31:0];
        t = int'(s[31:0]);
        r.ovf = (s != longint'(t));
      end
      4'h6: r.res = (sa < sb) ? 32'd1 : 32'd0;
      4'h7: r.res = (ua < ub) ? 32'd1 : 32'd0;
      4'h8: r.res = b << sh;
      4'h9: r.res = b >> sh;
      4'hA: begin
        s = sb >>> sh;
        r.res = s[31:0];
      end
      4'hB: begin
        p = ua * ub;
        r.res = p[31:0];
        r.hi  = p[63:32];
      end
      default: r.err = 1'b1;
    endcase
    r.zero = (op == 4'hB) ? (p == 64'd0) : (r.res == 32'd0);
    return r;
  endfunction

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Compare the output register against an expected record right now.
  task automatic checkRes(input string name, input res_t exp);
    res_t act;
    act = {out_result, out_hi, out_zero, out_ovf, out_err};
    tests++;
    if (out_valid !== 1'b1 || act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got valid=%b res=%h hi=%h z=%b o=%b e=%b, expected valid=1 res=%h hi=%h z=%b o=%b e=%b",
               name, out_valid, act.res, act.hi, act.zero, act.ovf, act.err,
               exp.res, exp.hi, exp.zero, exp.ovf, exp.err);
    end
  endtask

  // Present one op and return just after the edge that accepted it.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int waited = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("[TB] FAIL accept_timeout: in_ready stayed 0, expected 1");
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  // Wait (bounded) for a held result, then compare it.
  task automatic checkOutput(input string name, input res_t exp);
    int waited = 0;
    @(negedge clk);
    while (!out_valid && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    checkRes(name, exp);
  endtask

  vec_t        vecs[$];
  res_t        exp_q[$];
  res_t        held;
  logic [31:0] specials [5];
  logic [31:0] ra, rb;
  logic [3:0]  rop;
  int          n;
  logic        seen;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    specials = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};

    vecs.push_back('{ALU_NOR,   32'h0F0F_0000, 32'h00FF_00FF, '{32'hF000_FF00, 32'h0, 1'b0, 1'b0, 1'b0}});
    vecs.push_back('{ALU_AND,   32'hF0F0_F0F0, 32'hFF00_FF00, '{32'hF000_F000, 32'h0, 1'b0, 1'b0, 1'b0}});
    vecs.push_back('{ALU_OR,    32'h0,         32'h0,         '{32'h0,         32'h0, 1'b1, 1'b0, 1'b0}});
    vecs.push_back('{ALU_ADD,   32'h7FFF_FFFF, 32'h1,         '{32'h8000_0000, 32'h0, 1'b0, 1'b1, 1'b0}});
    vecs.push_back('{ALU_ADD,   32'hFFFF_FFFF, 32'h1,         '{32'h0,         32'h0, 1'b1, 1'b0, 1'b0}});
    vecs.push_back('{ALU_SUB,   32'h5,         32'h5,         '{32'h0,         32'h0, 1'b1, 1'b0, 1'b0}});
    vecs.push_back('{ALU_SUB,   32'h8000_0000, 32'h1,         '{32'h7FFF_FFFF, 32'h0, 1'b0, 1'b1, 1'b0}});
    vecs.push_back('{ALU_SLT,   32'hFFFF_FFFF, 32'h1,         '{32'h1,         32'h0, 1'b0, 1'b0, 1'b0}});
    vecs.push_back('{ALU_SLTU,  32'hFFFF_FFFF, 32'h1,         '{32'h0,         32'h0, 1'b1, 1'b0, 1'b0}});
    vecs.push_back('{ALU_SRA,   32'd31,        32'h8000_0000, '{32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b0}});
    vecs.push_back('{ALU_SRL,   32'd4,         32'h8000_0000, '{32'h0800_0000, 32'h0, 1'b0, 1'b0, 1'b0}});
    vecs.push_back('{ALU_SLL,   32'd0,         32'h1234_5678, '{32'h1234_5678, 32'h0, 1'b0, 1'b0, 1'b0}});
    vecs.push_back('{4'hE,      32'h1234,      32'h5678,      '{32'h0,         32'h0, 1'b1, 1'b0, 1'b1}});
    vecs.push_back('{ALU_MULTU, 32'h0,         32'h1234,      '{32'h0,         32'h0, 1'b1, 1'b0, 1'b0}});

    // Reset held with a pending op: nothing accepted, outputs cleared.
    in_valid = 1'b1;
    in_op    = ALU_ADD;
    in_a     = 32'h1;
    in_b     = 32'h2;
    repeat (3) @(negedge clk);
    checkVal("reset_ctrl", {62'd0, out_valid, in_ready}, 64'd0);
    checkVal("reset_data", {out_result, out_hi}, 64'd0);
    checkVal("reset_flags", {61'd0, out_zero, out_ovf, out_err}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkVal("ready_after_reset", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b0;

    // Directed vector table.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
      checkOutput($sformatf("vec%0d_op%0h", i, vecs[i].op), vecs[i].exp);
    end

    // Back-to-back XOR stream: one result per cycle, no bubble.
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = ALU_XOR;
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom;
      in_a = ra;
      in_b = rb;
      exp_q.push_back(refModel(ALU_XOR, ra, rb));
      @(negedge clk);
      checkRes("xor_stream", exp_q.pop_front());
    end
    in_valid = 1'b0;

    // MULTU worst case: latency, in_ready low throughout, full 64-bit product.
    applyStimulus(ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    n = 0;
    seen = in_ready;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (!out_valid && in_ready) seen = 1'b1;
    end
    checkVal("multu_latency", 64'(n), 64'd32);
    checkVal("multu_in_ready_low", {63'd0, seen}, 64'd0);
    checkOutput("multu_ffff", '{32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0});

    // Reset at iteration 10 of a multiply: no partial result ever appears.
    applyStimulus(ALU_MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checkVal("reset_mid_mul_no_valid", {63'd0, seen}, 64'd0);
    checkVal("ready_after_mul_abort", {63'd0, in_ready}, 64'd1);

    // Backpressure: ADD result held stable for 5 cycles while an XOR waits.
    out_ready = 1'b0;
    held = refModel(ALU_ADD, 32'd100, 32'd23);
    applyStimulus(ALU_ADD, 32'd100, 32'd23);
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = ALU_XOR;
    in_a     = 32'hAAAA_5555;
    in_b     = 32'h0F0F_0F0F;
    for (int k = 0; k < 5; k++) begin
      checkRes("stall_hold", held);
      checkVal("stall_in_ready", {63'd0, in_ready}, 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checkRes("stall_release_xor", refModel(ALU_XOR, 32'hAAAA_5555, 32'h0F0F_0F0F));
    in_valid = 1'b0;

    // Randomized ops with corner-value operands against the reference model.
    for (int i = 0; i < 150; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
      applyStimulus(rop, ra, rb);
      checkOutput($sformatf("rand%0d_op%0h", i, rop), refModel(rop, ra, rb));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
